// File: rtl/vga_pkg.sv
// Shared timing constants, window geometry and pixel field layout
// for the VGA scan-out path.
package vga_pkg;

    localparam int H_VIS_D  = 640;
    localparam int H_FP_D   = 16;
    localparam int H_SYNC_D = 96;
    localparam int H_BP_D   = 48;
    localparam int V_VIS_D  = 480;
    localparam int V_FP_D   = 10;
    localparam int V_SYNC_D = 2;
    localparam int V_BP_D   = 33;

    localparam int WIN_X0_D = 64;
    localparam int WIN_Y0_D = 48;
    localparam int WIN_W_D  = 512;
    localparam int WIN_H_D  = 384;

    // RGB332 byte layout {r[2:0], g[2:0], b[1:0]}
    localparam int R_MSB = 7;
    localparam int R_LSB = 5;
    localparam int G_MSB = 4;
    localparam int G_LSB = 2;
    localparam int B_MSB = 1;
    localparam int B_LSB = 0;

    // Counters cover up to 1024 pixels per line / lines per frame
    typedef logic [9:0] cnt_t;

    // Per-pixel control bits carried alongside the address
    typedef struct packed {
        logic in_win;
        logic active;
        logic hs_n;
        logic vs_n;
    } ctl_t;

    localparam ctl_t CTL_RST = '{in_win: 1'b0, active: 1'b0,
                                 hs_n: 1'b1, vs_n: 1'b1};

endpackage

// File: rtl/vram_scanner_if.sv
// VRAM read port plus VGA pins of the scanner.
// master = scanner side, slave = VRAM/monitor side.
interface vram_scanner_if;

    logic [7:0]  vram_data;
    logic [15:0] vram_addr;
    logic [2:0]  vga_r;
    logic [2:0]  vga_g;
    logic [1:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        vblank_irq;

    modport master (
        input  vram_data,
        output vram_addr, vga_r, vga_g, vga_b,
        output vga_hs, vga_vs, vblank_irq
    );

    modport slave (
        output vram_data,
        input  vram_addr, vga_r, vga_g, vga_b,
        input  vga_hs, vga_vs, vblank_irq
    );

endinterface

// File: rtl/vga_timing.sv
// Pixel divider, h/v raster counters, raw sync/window decode
// and the one-clk vblank pulse.
module vga_timing
    import vga_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int H_VIS   = H_VIS_D,
    parameter int H_FP    = H_FP_D,
    parameter int H_SYNC  = H_SYNC_D,
    parameter int H_BP    = H_BP_D,
    parameter int V_VIS   = V_VIS_D,
    parameter int V_FP    = V_FP_D,
    parameter int V_SYNC  = V_SYNC_D,
    parameter int V_BP    = V_BP_D,
    parameter int WIN_X0  = WIN_X0_D,
    parameter int WIN_Y0  = WIN_Y0_D,
    parameter int WIN_W   = WIN_W_D,
    parameter int WIN_H   = WIN_H_D
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       tick_o,
    output ctl_t       ctl_o,
    output logic [7:0] fb_x_o,
    output logic [7:0] fb_y_o,
    output logic       irq_o
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DW    = $clog2(CLK_DIV);

    localparam cnt_t H_LAST = cnt_t'(H_TOT - 1);
    localparam cnt_t V_LAST = cnt_t'(V_TOT - 1);
    localparam cnt_t V_IRQ  = cnt_t'(V_VIS - 1);
    localparam cnt_t HS_ON  = cnt_t'(H_VIS + H_FP);
    localparam cnt_t HS_OFF = cnt_t'(H_VIS + H_FP + H_SYNC);
    localparam cnt_t VS_ON  = cnt_t'(V_VIS + V_FP);
    localparam cnt_t VS_OFF = cnt_t'(V_VIS + V_FP + V_SYNC);
    localparam cnt_t WX0    = cnt_t'(WIN_X0);
    localparam cnt_t WX1    = cnt_t'(WIN_X0 + WIN_W);
    localparam cnt_t WY0    = cnt_t'(WIN_Y0);
    localparam cnt_t WY1    = cnt_t'(WIN_Y0 + WIN_H);

    logic [DW-1:0] div_q, div_d;
    cnt_t          h_q, h_d;
    cnt_t          v_q, v_d;
    logic          irq_q, irq_d;
    logic          tick;

    assign tick = (div_q == DW'(CLK_DIV - 1));

    // Next state: divider always runs, counters step on tick
    always_comb begin
        div_d = tick ? '0 : div_q + 1'b1;
        h_d   = h_q;
        v_d   = v_q;
        if (tick) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
        irq_d = tick && (h_q == H_LAST) && (v_q == V_IRQ);
    end

    // Raster state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
            irq_q <= 1'b0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
            irq_q <= irq_d;
        end
    end

    // Raw decode of the current raster position
    always_comb begin
        ctl_o.hs_n   = !((h_q >= HS_ON) && (h_q < HS_OFF));
        ctl_o.vs_n   = !((v_q >= VS_ON) && (v_q < VS_OFF));
        ctl_o.active = (h_q < cnt_t'(H_VIS)) && (v_q < cnt_t'(V_VIS));
        ctl_o.in_win = (h_q >= WX0) && (h_q < WX1) &&
                       (v_q >= WY0) && (v_q < WY1);
        fb_x_o = 8'((h_q - WX0) >> 1);
        fb_y_o = 8'((v_q - WY0) >> 1);
    end

    assign tick_o = tick;
    assign irq_o  = irq_q;

endmodule

// File: rtl/vram_scanner.sv
// VRAM-to-VGA scan-out: address stage, colour stage and
// output pins, driven by the raster generator.
module vram_scanner
    import vga_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int H_VIS   = H_VIS_D,
    parameter int H_FP    = H_FP_D,
    parameter int H_SYNC  = H_SYNC_D,
    parameter int H_BP    = H_BP_D,
    parameter int V_VIS   = V_VIS_D,
    parameter int V_FP    = V_FP_D,
    parameter int V_SYNC  = V_SYNC_D,
    parameter int V_BP    = V_BP_D,
    parameter int WIN_X0  = WIN_X0_D,
    parameter int WIN_Y0  = WIN_Y0_D,
    parameter int WIN_W   = WIN_W_D,
    parameter int WIN_H   = WIN_H_D
) (
    input  logic           clk,
    input  logic           rst_n,
    vram_scanner_if.master bus
);

    logic       tick;
    ctl_t       ctl;
    logic [7:0] fb_x;
    logic [7:0] fb_y;
    logic       irq;

    ctl_t        s1_q, s1_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  rgb_q, rgb_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;

    vga_timing #(
        .CLK_DIV (CLK_DIV),
        .H_VIS   (H_VIS),
        .H_FP    (H_FP),
        .H_SYNC  (H_SYNC),
        .H_BP    (H_BP),
        .V_VIS   (V_VIS),
        .V_FP    (V_FP),
        .V_SYNC  (V_SYNC),
        .V_BP    (V_BP),
        .WIN_X0  (WIN_X0),
        .WIN_Y0  (WIN_Y0),
        .WIN_W   (WIN_W),
        .WIN_H   (WIN_H)
    ) u_timing (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (tick),
        .ctl_o  (ctl),
        .fb_x_o (fb_x),
        .fb_y_o (fb_y),
        .irq_o  (irq)
    );

    // Both stages advance together on the pixel tick
    always_comb begin
        s1_d   = s1_q;
        addr_d = addr_q;
        rgb_d  = rgb_q;
        hs_d   = hs_q;
        vs_d   = vs_q;
        if (tick) begin
            s1_d   = ctl;
            addr_d = ctl.in_win ? {fb_y, fb_x} : 16'h0000;
            rgb_d  = (s1_q.in_win && s1_q.active) ?
                     bus.vram_data : 8'h00;
            hs_d   = s1_q.hs_n;
            vs_d   = s1_q.vs_n;
        end
    end

    // Pipeline and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= CTL_RST;
            addr_q <= 16'h0000;
            rgb_q  <= 8'h00;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
        end else begin
            s1_q   <= s1_d;
            addr_q <= addr_d;
            rgb_q  <= rgb_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
        end
    end

    assign bus.vram_addr  = addr_q;
    assign bus.vga_r      = rgb_q[R_MSB:R_LSB];
    assign bus.vga_g      = rgb_q[G_MSB:G_LSB];
    assign bus.vga_b      = rgb_q[B_MSB:B_LSB];
    assign bus.vga_hs     = hs_q;
    assign bus.vga_vs     = vs_q;
    assign bus.vblank_irq = irq;

endmodule

// File: tb/tb_vram_scanner.sv
// Bench for vram_scanner: full-size horizontal timing on one
// instance, a shrunken raster on a second for whole frames.
module tb_vram_scanner;

    typedef struct packed {
        int div;
        int hvis; int hfp; int hsync; int hbp;
        int vvis; int vfp; int vsync; int vbp;
        int wx; int wy; int ww; int wh;
    } cfg_t;

    localparam int B_DIV = 3;
    localparam int B_HVIS = 96, B_HFP = 4, B_HSYNC = 8, B_HBP = 12;
    localparam int B_VVIS = 40, B_VFP = 2, B_VSYNC = 2, B_VBP = 4;
    localparam int B_WX = 16, B_WY = 8, B_WW = 32, B_WH = 20;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    bit   mode;
    logic [7:0] mem [0:65535];
    cfg_t cfg [2];
    longint ck [2];
    longint kk [2];
    bit     ie [2];
    longint nirq [2];

    vram_scanner_if ifa ();
    vram_scanner_if ifb ();

    vram_scanner #(
        .CLK_DIV (2),
        .WIN_Y0  (0)
    ) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    vram_scanner #(
        .CLK_DIV (B_DIV),
        .H_VIS (B_HVIS), .H_FP (B_HFP), .H_SYNC (B_HSYNC), .H_BP (B_HBP),
        .V_VIS (B_VVIS), .V_FP (B_VFP), .V_SYNC (B_VSYNC), .V_BP (B_VBP),
        .WIN_X0 (B_WX), .WIN_Y0 (B_WY), .WIN_W (B_WW), .WIN_H (B_WH)
    ) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] vram(logic [15:0] a);
        return mode ? mem[a] : a[7:0];
    endfunction

    // VRAM: data valid one clk after address
    always @(posedge clk) begin
        ifa.vram_data <= vram(ifa.vram_addr);
        ifb.vram_data <= vram(ifb.vram_addr);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int line_len(cfg_t c);
        return c.hvis + c.hfp + c.hsync + c.hbp;
    endfunction

    function automatic int frame_lines(cfg_t c);
        return c.vvis + c.vfp + c.vsync + c.vbp;
    endfunction

    function automatic longint frame_ticks(cfg_t c);
        return longint'(line_len(c)) * frame_lines(c);
    endfunction

    function automatic int h_of(cfg_t c, longint p);
        return int'((p % frame_ticks(c)) % line_len(c));
    endfunction

    function automatic int v_of(cfg_t c, longint p);
        return int'((p % frame_ticks(c)) / line_len(c));
    endfunction

    function automatic bit win_at(cfg_t c, longint p);
        int h = h_of(c, p);
        int v = v_of(c, p);
        return h >= c.wx && h < c.wx + c.ww &&
               v >= c.wy && v < c.wy + c.wh;
    endfunction

    function automatic logic [15:0] addr_at(cfg_t c, longint p);
        if (!win_at(c, p)) return 16'h0000;
        return {8'((v_of(c, p) - c.wy) / 2), 8'((h_of(c, p) - c.wx) / 2)};
    endfunction

    function automatic logic [7:0] rgb_at(cfg_t c, longint p);
        if (h_of(c, p) < c.hvis && v_of(c, p) < c.vvis && win_at(c, p))
            return vram(addr_at(c, p));
        return 8'h00;
    endfunction

    function automatic logic hs_at(cfg_t c, longint p);
        int h = h_of(c, p);
        return !(h >= c.hvis + c.hfp && h < c.hvis + c.hfp + c.hsync);
    endfunction

    function automatic logic vs_at(cfg_t c, longint p);
        int v = v_of(c, p);
        return !(v >= c.vvis + c.vfp && v < c.vvis + c.vfp + c.vsync);
    endfunction

    function automatic longint irq_pos(cfg_t c);
        return longint'(c.vvis) * line_len(c);
    endfunction

    function automatic longint e_frames(int i, longint k);
        if (k < irq_pos(cfg[i])) return 0;
        return (k - irq_pos(cfg[i])) / frame_ticks(cfg[i]) + 1;
    endfunction

    // Reference: kk = pixel ticks since reset release, position = kk
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                ck[i] <= 0;
                kk[i] <= 0;
                ie[i] <= 1'b0;
            end else begin
                ck[i] <= ck[i] + 1;
                if ((ck[i] + 1) % cfg[i].div == 0) begin
                    kk[i] <= kk[i] + 1;
                    ie[i] <= ((kk[i] + 1) % frame_ticks(cfg[i]))
                             == irq_pos(cfg[i]);
                end else begin
                    ie[i] <= 1'b0;
                end
            end
        end
    end

    task automatic mon(input int i, input string nm,
                       input logic [15:0] a, input logic [7:0] rgb,
                       input logic hs, input logic vs, input logic irq);
        longint k = kk[i];
        chk({nm, ".addr"}, 32'(a),
            32'(k >= 1 ? addr_at(cfg[i], k - 1) : 16'h0));
        chk({nm, ".rgb"}, 32'(rgb),
            32'(k >= 2 ? rgb_at(cfg[i], k - 2) : 8'h0));
        chk({nm, ".hs"}, 32'(hs), 32'(k >= 2 ? hs_at(cfg[i], k - 2) : 1'b1));
        chk({nm, ".vs"}, 32'(vs), 32'(k >= 2 ? vs_at(cfg[i], k - 2) : 1'b1));
        chk({nm, ".irq"}, 32'(irq), 32'(ie[i]));
        if (!rst_n) nirq[i] = 0;
        else if (irq === 1'b1) nirq[i]++;
    endtask

    always @(negedge clk) begin
        mon(0, "A", ifa.vram_addr, {ifa.vga_r, ifa.vga_g, ifa.vga_b},
            ifa.vga_hs, ifa.vga_vs, ifa.vblank_irq);
        mon(1, "B", ifb.vram_addr, {ifb.vga_r, ifb.vga_g, ifb.vga_b},
            ifb.vga_hs, ifb.vga_vs, ifb.vblank_irq);
    end

    task automatic chk_rst(input string nm, input logic [15:0] a,
                           input logic [7:0] rgb, input logic hs,
                           input logic vs, input logic irq);
        chk({nm, ".arst_addr"}, 32'(a), 32'h0);
        chk({nm, ".arst_rgb"}, 32'(rgb), 32'h0);
        chk({nm, ".arst_hs"}, 32'(hs), 32'h1);
        chk({nm, ".arst_vs"}, 32'(vs), 32'h1);
        chk({nm, ".arst_irq"}, 32'(irq), 32'h0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        mode  = 1'b0;
        nirq  = '{0, 0};
        rst_n = 1'b0;
        cfg[0] = '{div: 2, hvis: 640, hfp: 16, hsync: 96, hbp: 48,
                   vvis: 480, vfp: 10, vsync: 2, vbp: 33,
                   wx: 64, wy: 0, ww: 512, wh: 384};
        cfg[1] = '{div: B_DIV, hvis: B_HVIS, hfp: B_HFP, hsync: B_HSYNC,
                   hbp: B_HBP, vvis: B_VVIS, vfp: B_VFP, vsync: B_VSYNC,
                   vbp: B_VBP, wx: B_WX, wy: B_WY, ww: B_WW, wh: B_WH};
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);

        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (3300) @(negedge clk);

        repeat ($urandom_range(50, 400)) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_rst("A", ifa.vram_addr, {ifa.vga_r, ifa.vga_g, ifa.vga_b},
                ifa.vga_hs, ifa.vga_vs, ifa.vblank_irq);
        chk_rst("B", ifb.vram_addr, {ifb.vga_r, ifb.vga_g, ifb.vga_b},
                ifb.vga_hs, ifb.vga_vs, ifb.vblank_irq);
        mode = 1'b1;
        repeat ($urandom_range(2, 5)) @(negedge clk);
        rst_n = 1'b1;
        repeat (36000) @(negedge clk);
        #2;
        chk("A.irq_count", 32'(nirq[0]), 32'(e_frames(0, kk[0])));
        chk("B.irq_count", 32'(nirq[1]), 32'(e_frames(1, kk[1])));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vram_scanner.md
# vram_scanner

Display-side reader of the video RAM: the CPU writes 8-bit pixels into VRAM through the system bus, and this block reads them back continuously and drives a 640x480@60 VGA port. Framebuffer is 256x192 RGB332, each pixel shown as 2x2 screen pixels in a centred 512x384 window with a black border. The block also raises a once-per-frame vblank pulse so game software can update VRAM without tearing.

## Interface
- CLK_DIV, 2: system clocks per pixel; pixel tick every CLK_DIV clocks; legal values ≥2.
- H_VIS / H_FP / H_SYNC / H_BP, 640 / 16 / 96 / 48: horizontal timing in pixels; line length 800.
- V_VIS / V_FP / V_SYNC / V_BP, 480 / 10 / 2 / 33: vertical timing in lines; frame length 525.
- WIN_X0 / WIN_Y0, 64 / 48: top-left screen coordinate of the 512x384 window.

- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- vram_data  in  8  VRAM read data, RGB332 {r[2:0],g[2:0],b[1:0]}; valid one clk after vram_addr.
- vram_addr  out  16  VRAM read address {fb_y[7:0], fb_x[7:0]}; registered.
- vga_r  out  3  red.
- vga_g  out  3  green.
- vga_b  out  2  blue.
- vga_hs  out  1  hsync, active low.
- vga_vs  out  1  vsync, active low.
- vblank_irq  out  1  one-clk pulse at start of vertical blanking.

## Operation
- Pixel tick: divider counts 0..CLK_DIV-1; tick asserted when divider = CLK_DIV-1. All counters and pipeline registers advance only on tick (except vblank_irq, a single-clk pulse).
- Counters: h 0..799, v 0..524. On tick h increments; h=799 → h=0 and v increments; v=524 with h=799 → v=0.
- Sync (from counters): hs_n = 0 iff 656 ≤ h < 752; vs_n = 0 iff 490 ≤ v < 492. Active = h<640 && v<480.
- Window: in_win = 64 ≤ h < 576 && 48 ≤ v < 432. fb_x = (h-64)>>1 (0..255), fb_y = (v-48)>>1 (0..191). Max address 0xBFFF; 0xC000-0xFFFF never read.
- Stage 1 (tick): vram_addr ← in_win ? {fb_y,fb_x} : 16'h0000; in_win, active, hs_n, vs_n delayed one stage.
- Stage 2 (tick): {vga_r,vga_g,vga_b} ← (stage-1 in_win && active) ? vram_data : 0; vga_hs/vga_vs ← stage-1 sync. Data is sampled ≥CLK_DIV-1 ≥1 clk after address change, satisfying the 1-clk VRAM latency.
- Border and blanking always output 0; VRAM contents ignored there.
- vblank_irq: high for exactly one clk, on the clk where the tick moves counters to (h=0, v=480).
- No write path; VRAM contention is resolved by the dual-port VRAM, not here.

## Timing
- Reset values: divider 0, h=0, v=0, vram_addr=0, rgb=0, vga_hs=1, vga_vs=1, vblank_irq=0, all pipeline regs 0/inactive-high syncs.
- Reset asserted mid-frame: all outputs return to reset values immediately (async); after release scanning restarts at (0,0), first tick CLK_DIV clks later.
- Latency: counter value → pins = 2 ticks, identical for rgb, hs, vs (syncs and colour stay aligned).
- Pin timing relative to counters: vga_hs low for 96 ticks starting 2 ticks after h=656; line period 800 ticks; frame period 420000 ticks (840000 clk at CLK_DIV=2).
- Each fb pixel repeats 2 adjacent ticks and 2 adjacent lines; vram_addr changes at most every 2 ticks inside window.
- Wrap: h 799→0 and v 524→0 on same tick with no extra cycle.

## Structure
- Shared package vga_pkg: 640x480 timing constants, window origin/size, RGB332 field slicing constants.
- Sub-module vga_timing: divider, h/v counters, raw sync/active/in_win, fb_x/fb_y, vblank_irq. vram_scanner holds the two pipeline stages and output registers.

## Test plan
- Reset held then released, CLK_DIV=2: first 3 ticks → vga_hs=vga_vs=1, rgb=0, vram_addr=0.
- Free run one line: vga_hs falls exactly 2 ticks after h=656, stays low 96 ticks; line period 800 ticks (1600 clk).
- VRAM model returns addr[7:0] as data: pixel at h=64,65 shows 0x00; h=66,67 shows 0x01; h=574,575 shows 0xFF; h=576 and h<64 show 0.
- Window vertical: lines v=48,49 drive vram_addr[15:8]=0x00; v=430,431 → 0xBF; v=432 → vram_addr=0, rgb=0.
- vblank_irq: exactly one single-clk pulse per 840000 clk, coincident with counters reaching (0,480); vga_vs low for 2 lines starting v=490 (+2 ticks).
- Async reset asserted at (300,200) mid-pixel: outputs reset same clk without clock edge; after release rgb/sync timing matches a fresh start from (0,0).
